// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - dt_tree_engine configuration, node-entry layout, states, child selection
// The widths here are the single source for the node-table layout used by the engine and RAM.
package dt_pkg;
  localparam int N_FEAT    = 51;
  localparam int NODES     = 32;
  localparam int CLASS_W   = 3;
  localparam int MAX_STEPS = 16;

  localparam int NODE_W = $clog2(NODES);
  localparam int FIDX_W = $clog2(N_FEAT);
  localparam int NE_W   = 1 + FIDX_W + 2*NODE_W + CLASS_W;
  localparam int STEP_W = $clog2(MAX_STEPS) + 1;

  localparam int CLS_LSB  = 0;
  localparam int F_LSB    = CLASS_W;
  localparam int T_LSB    = CLASS_W + NODE_W;
  localparam int FIDX_LSB = CLASS_W + 2*NODE_W;
  localparam int LEAF_BIT = NE_W - 1;

  typedef struct packed {
    logic              leaf;
    logic [FIDX_W-1:0] fidx;
    logic [NODE_W-1:0] t_child;
    logic [NODE_W-1:0] f_child;
    logic [CLASS_W-1:0] cls;
  } node_t;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WALK = 2'd1;
  localparam state_t DONE = 2'd2;

  // Out-of-range indices read a zero pad bit; the engine aborts on them before this matters.
  function automatic logic [NODE_W-1:0] f_next(input node_t node, input logic [N_FEAT-1:0] feat);
    logic [(1<<FIDX_W)-1:0] padded;
    padded = '0;
    padded[N_FEAT-1:0] = feat;
    return padded[node.fidx] ? node.t_child : node.f_child;
  endfunction
endpackage

// File: rtl/dt_node_ram.sv
// rtl/dt_node_ram.sv - register-based node table, async clear, sync write, combinational read
module dt_node_ram
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [NODE_W-1:0] waddr,
  input  logic [NE_W-1:0]   wdata,
  input  logic [NODE_W-1:0] raddr,
  output logic [NE_W-1:0]   rdata
);
  logic [NE_W-1:0] mem [NODES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dt_tree_engine.sv
// rtl/dt_tree_engine.sv - sequential decision-tree walker, one node per clock, valid/ready in and out
module dt_tree_engine
  import dt_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [NODE_W-1:0]  cfg_addr,
  input  logic [NE_W-1:0]    cfg_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [N_FEAT-1:0]  s_feat,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CLASS_W-1:0] m_class,
  output logic               m_err,
  output logic               busy
);
  state_t              state;
  logic [N_FEAT-1:0]   feat_q;
  logic [NODE_W-1:0]   cur;
  logic [STEP_W-1:0]   step;
  logic [NE_W-1:0]     rd;
  node_t               node;

  // Table is writable only while idle, so a walk always sees a frozen tree.
  dt_node_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we && (state == IDLE)),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (cur),
    .rdata (rd)
  );

  assign node    = node_t'(rd);
  assign s_ready = (state == IDLE);
  assign busy    = (state == WALK);
  assign m_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      feat_q  <= '0;
      cur     <= '0;
      step    <= '0;
      m_class <= '0;
      m_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            feat_q <= s_feat;
            cur    <= '0;
            step   <= '0;
            state  <= WALK;
          end
        end
        WALK: begin
          if (node.leaf) begin
            m_class <= node.cls;
            m_err   <= 1'b0;
            state   <= DONE;
          end else if (int'(node.fidx) >= N_FEAT || step == STEP_W'(MAX_STEPS-1)) begin
            m_class <= '0;
            m_err   <= 1'b1;
            state   <= DONE;
          end else begin
            cur  <= f_next(node, feat_q);
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (m_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dt_tree_engine.sv
// tb/tb_dt_tree_engine.sv - randomized and directed bench for dt_tree_engine against a tree-walk model
module tb_dt_tree_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [19:0] cfg_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [50:0] s_feat = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [2:0]  m_class;
  logic        m_err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int m_leaf [32];
  int m_fidx [32];
  int m_t    [32];
  int m_f    [32];
  int m_cls  [32];

  bit txn_active = 0;
  int acc_cyc = 0;
  int exp_n = 0;
  int exp_cls = 0;
  int exp_err = 0;

  dt_tree_engine dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_feat(s_feat),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_err(m_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] pack(input int leaf, input int fidx, input int t, input int fe, input int cls);
    return {1'(leaf), 6'(fidx), 5'(t), 5'(fe), 3'(cls)};
  endfunction

  function automatic logic [50:0] rnd_feat();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[50:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_leaf[i] = 0; m_fidx[i] = 0; m_t[i] = 0; m_f[i] = 0; m_cls[i] = 0;
    end
  endtask

  task automatic model_set(input int a, input int leaf, input int fidx, input int t, input int fe, input int cls);
    m_leaf[a] = leaf; m_fidx[a] = fidx; m_t[a] = t; m_f[a] = fe; m_cls[a] = cls;
  endtask

  // Walk the tree as described: visit nodes, count them, abort on bad index or step limit.
  task automatic model_walk(input logic [50:0] f, output int cls, output int err, output int n);
    int cur;
    cur = 0; n = 0; cls = 0; err = 1;
    for (int s = 0; s < 16; s++) begin
      n++;
      if (m_leaf[cur] != 0) begin
        cls = m_cls[cur]; err = 0; return;
      end
      if (m_fidx[cur] >= 51 || s == 15) begin
        cls = 0; err = 1; return;
      end
      cur = f[m_fidx[cur]] ? m_t[cur] : m_f[cur];
    end
  endtask

  task automatic cfg_write(input int a, input int leaf, input int fidx, input int t, input int fe, input int cls);
    model_set(a, leaf, fidx, t, fe, cls);
    cfg_we = 1'b1; cfg_addr = 5'(a); cfg_data = pack(leaf, fidx, t, fe, cls);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic run_txn(input logic [50:0] f, input int hold, input int lat_lit, input int cls_lit, input int err_lit);
    int n, mcls, merr, waited, held, lat;
    bit hs, v, r, seen;
    model_walk(f, mcls, merr, n);
    if (lat_lit > 0) check("model_latency", n + 1, lat_lit);
    if (cls_lit >= 0) check("model_class", mcls, cls_lit);
    if (err_lit >= 0) check("model_err", merr, err_lit);
    s_feat = f; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; cfg_we = 1'b0; s_feat = rnd_feat();
    exp_n = n; exp_cls = mcls; exp_err = merr; acc_cyc = cyc; txn_active = 1;
    hs = 0; waited = 0; held = 0; seen = 0;
    while (!hs && waited < 100) begin
      if (m_valid && !seen) begin
        seen = 1;
        lat = cyc - acc_cyc + 1;
        if (lat_lit > 0) check("dut_latency", lat, lat_lit);
      end
      cfg_we = 1'($urandom_range(0, 1)); cfg_addr = 5'($urandom()); cfg_data = 20'($urandom());
      if (m_valid) begin
        m_ready = (held >= hold);
        if (held < hold) held++;
        cfg_we = 1'b1; cfg_addr = '0; cfg_data = pack(1, 0, 0, 0, 7);
      end else begin
        m_ready = 1'($urandom_range(0, 1));
      end
      v = m_valid; r = m_ready;
      @(posedge clk); #1;
      waited++;
      if (v && r) hs = 1;
    end
    cfg_we = 1'b0; m_ready = 1'($urandom_range(0, 1)); txn_active = 0;
    check("handshake_seen", int'(hs), 1);
  endtask

  // Cycle-level compare: each transaction's timeline follows from its accept edge and path length.
  always @(negedge clk) begin
    if (!rst) begin
      if (!txn_active) begin
        check("idle_s_ready", int'(s_ready), 1);
        check("idle_busy", int'(busy), 0);
        check("idle_m_valid", int'(m_valid), 0);
      end else if (cyc < acc_cyc + exp_n) begin
        check("walk_s_ready", int'(s_ready), 0);
        check("walk_busy", int'(busy), 1);
        check("walk_m_valid", int'(m_valid), 0);
      end else begin
        check("done_s_ready", int'(s_ready), 0);
        check("done_busy", int'(busy), 0);
        check("done_m_valid", int'(m_valid), 1);
        check("done_m_class", int'(m_class), exp_cls);
        check("done_m_err", int'(m_err), exp_err);
      end
    end
  end

  initial begin
    logic [50:0] f;
    int n, c, e;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_class", int'(m_class), 0);
    check("rst_m_err", int'(m_err), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    cfg_write(0, 1, 0, 0, 0, 5);
    run_txn(rnd_feat(), 0, 2, 5, 0);

    cfg_write(0, 0, 10, 1, 2, 0);
    cfg_write(1, 0, 39, 3, 4, 0);
    cfg_write(3, 1, 0, 0, 0, 2);
    cfg_write(4, 1, 0, 0, 0, 6);
    cfg_write(2, 1, 0, 0, 0, 0);
    f = rnd_feat(); f[10] = 1'b1; f[39] = 1'b1;
    run_txn(f, 0, 4, 2, 0);
    f = rnd_feat(); f[10] = 1'b1; f[39] = 1'b0;
    run_txn(f, 1, 4, 6, 0);
    f = rnd_feat(); f[10] = 1'b0;
    run_txn(f, 0, 3, 0, 0);

    cfg_write(0, 0, 0, 0, 0, 0);
    run_txn(rnd_feat(), 0, 17, 0, 1);

    cfg_write(0, 0, 60, 1, 2, 0);
    run_txn(rnd_feat(), 0, 2, 0, 1);

    cfg_write(0, 1, 0, 0, 0, 5);
    run_txn(rnd_feat(), 5, 2, 5, 0);
    run_txn(rnd_feat(), 0, 2, 5, 0);

    model_set(0, 1, 0, 0, 0, 3);
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = pack(1, 0, 0, 0, 3);
    run_txn(rnd_feat(), 0, 2, 3, 0);

    cfg_write(0, 0, 0, 0, 0, 0);
    f = rnd_feat();
    model_walk(f, c, e, n);
    s_feat = f; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    exp_n = n; exp_cls = c; exp_err = e; acc_cyc = cyc; txn_active = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; txn_active = 0;
    #1;
    check("midrst_s_ready", int'(s_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_m_class", int'(m_class), 0);
    check("midrst_m_err", int'(m_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    run_txn(rnd_feat(), 0, 17, 0, 1);

    for (int i = 0; i < 32; i++)
      cfg_write(i, ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 56),
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7));
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3))
        cfg_write($urandom_range(0, 31), ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 56),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7));
      run_txn(rnd_feat(), $urandom_range(0, 3), 0, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
